// File: rtl/ysyx_24120009_lut_pkg.sv
// Shared constants and helpers for the runtime-programmable key lookup table.
package ysyx_24120009_lut_pkg;

  localparam int unsigned PRIO_LOWEST = 1;
  localparam int unsigned PRIO_MERGE  = 0;

  // Index width for n entries; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/ysyx_24120009_match_encoder.sv
// Reduces a per-entry match vector to hit/multi flags, lowest index and result data.
module ysyx_24120009_match_encoder
  import ysyx_24120009_lut_pkg::*;
#(
  parameter int unsigned NR_KEY   = 4,
  parameter int unsigned DATA_LEN = 32,
  parameter int unsigned IDX_W    = 2,
  parameter int unsigned PRIORITY = PRIO_LOWEST
) (
  input  logic [NR_KEY-1:0]               match,
  input  logic [NR_KEY-1:0][DATA_LEN-1:0] data,
  output logic                            hit,
  output logic                            multi,
  output logic [IDX_W-1:0]                idx,
  output logic [DATA_LEN-1:0]             data_out
);

  logic [DATA_LEN-1:0] sel_data;
  logic [DATA_LEN-1:0] merged_data;

  // Ascending scan: the first match fixes idx/sel_data, any later one flags multi.
  always_comb begin
    hit         = 1'b0;
    multi       = 1'b0;
    idx         = '0;
    sel_data    = '0;
    merged_data = '0;
    for (int unsigned i = 0; i < NR_KEY; i++) begin
      if (match[i]) begin
        if (hit) begin
          multi = 1'b1;
        end else begin
          idx      = IDX_W'(i);
          sel_data = data[i];
        end
        hit         = 1'b1;
        merged_data = merged_data | data[i];
      end
    end
    data_out = (PRIORITY == PRIO_LOWEST) ? sel_data : merged_data;
  end

endmodule

// File: rtl/ysyx_24120009_mux_key_table.sv
// Programmable key->data table with a registered valid/ready lookup port.
module ysyx_24120009_mux_key_table
  import ysyx_24120009_lut_pkg::*;
#(
  parameter int unsigned NR_KEY      = 4,
  parameter int unsigned KEY_LEN     = 8,
  parameter int unsigned DATA_LEN    = 32,
  parameter bit          HAS_DEFAULT = 1'b1,
  parameter int unsigned PRIORITY    = PRIO_LOWEST
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [idx_width(NR_KEY)-1:0]   wr_idx,
  input  logic [KEY_LEN-1:0]             wr_key,
  input  logic [DATA_LEN-1:0]            wr_data,
  input  logic                           wr_valid,
  input  logic                           clear_all,
  input  logic [DATA_LEN-1:0]            default_out,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [KEY_LEN-1:0]             req_key,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [DATA_LEN-1:0]            rsp_data,
  output logic                           rsp_hit,
  output logic                           rsp_multi,
  output logic [idx_width(NR_KEY)-1:0]   rsp_idx
);

  localparam int unsigned IDX_W = idx_width(NR_KEY);

  logic [KEY_LEN-1:0]               keys [NR_KEY];
  logic [NR_KEY-1:0][DATA_LEN-1:0]  entry_data;
  logic [NR_KEY-1:0]                valid;
  logic [NR_KEY-1:0]                match;

  logic                enc_hit;
  logic                enc_multi;
  logic [IDX_W-1:0]    enc_idx;
  logic [DATA_LEN-1:0] enc_data;
  logic                accept;

  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;

  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < NR_KEY; i++) begin
      match[i] = valid[i] && (keys[i] == req_key);
    end
  end

  ysyx_24120009_match_encoder #(
    .NR_KEY   (NR_KEY),
    .DATA_LEN (DATA_LEN),
    .IDX_W    (IDX_W),
    .PRIORITY (PRIORITY)
  ) u_match_encoder (
    .match    (match),
    .data     (entry_data),
    .hit      (enc_hit),
    .multi    (enc_multi),
    .idx      (enc_idx),
    .data_out (enc_data)
  );

  // Per-entry decode keeps out-of-range wr_idx a natural no-op.
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < NR_KEY; i++) begin
      if (wr_en && (32'(wr_idx) == i)) begin
        keys[i]       <= wr_key;
        entry_data[i] <= wr_data;
      end
    end
  end

  // The addressed write takes precedence over clear_all for its own entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= '0;
    end else begin
      for (int unsigned i = 0; i < NR_KEY; i++) begin
        if (wr_en && (32'(wr_idx) == i)) begin
          valid[i] <= wr_valid;
        end else if (clear_all) begin
          valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_hit   <= 1'b0;
      rsp_multi <= 1'b0;
      rsp_idx   <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_hit   <= enc_hit;
      rsp_multi <= enc_multi;
      rsp_idx   <= enc_idx;
      if (enc_hit) begin
        rsp_data <= enc_data;
      end else begin
        rsp_data <= HAS_DEFAULT ? default_out : '0;
      end
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_24120009_mux_key_table.sv
// Bench for the key lookup table: priority/default and merge/no-default instances share stimulus.
module tb_ysyx_24120009_mux_key_table;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [1:0]  wr_idx;
  logic [7:0]  wr_key;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        clear_all;
  logic [31:0] default_out;
  logic        req_valid;
  logic [7:0]  req_key;
  logic        rsp_ready;

  logic        req_ready_p, rsp_valid_p, rsp_hit_p, rsp_multi_p;
  logic [31:0] rsp_data_p;
  logic [1:0]  rsp_idx_p;
  logic        req_ready_m, rsp_valid_m, rsp_hit_m, rsp_multi_m;
  logic [31:0] rsp_data_m;
  logic [1:0]  rsp_idx_m;

  int checks   = 0;
  int failures = 0;

  // Packed response view: {valid, hit, multi, idx[1:0], data[31:0]}
  logic [36:0] got_p, got_m;
  logic [36:0] exp_p, exp_m;
  assign got_p = {rsp_valid_p, rsp_hit_p, rsp_multi_p, rsp_idx_p, rsp_data_p};
  assign got_m = {rsp_valid_m, rsp_hit_m, rsp_multi_m, rsp_idx_m, rsp_data_m};

  logic [7:0]  m_key  [4];
  logic [31:0] m_data [4];
  bit          m_valid[4];

  always #5 clock = ~clock;

  ysyx_24120009_mux_key_table #(
    .NR_KEY(4), .KEY_LEN(8), .DATA_LEN(32), .HAS_DEFAULT(1'b1), .PRIORITY(1)
  ) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
    .wr_data(wr_data), .wr_valid(wr_valid), .clear_all(clear_all), .default_out(default_out),
    .req_valid(req_valid), .req_ready(req_ready_p), .req_key(req_key),
    .rsp_valid(rsp_valid_p), .rsp_ready(rsp_ready), .rsp_data(rsp_data_p),
    .rsp_hit(rsp_hit_p), .rsp_multi(rsp_multi_p), .rsp_idx(rsp_idx_p)
  );

  ysyx_24120009_mux_key_table #(
    .NR_KEY(4), .KEY_LEN(8), .DATA_LEN(32), .HAS_DEFAULT(1'b0), .PRIORITY(0)
  ) dut_m (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
    .wr_data(wr_data), .wr_valid(wr_valid), .clear_all(clear_all), .default_out(default_out),
    .req_valid(req_valid), .req_ready(req_ready_m), .req_key(req_key),
    .rsp_valid(rsp_valid_m), .rsp_ready(rsp_ready), .rsp_data(rsp_data_m),
    .rsp_hit(rsp_hit_m), .rsp_multi(rsp_multi_m), .rsp_idx(rsp_idx_m)
  );

  // Table lookup straight from the matching rules: count matches, lowest index, OR of data.
  function automatic logic [36:0] model_rsp(input logic [7:0] key, input bit prio,
                                            input bit hasdef, input logic [31:0] dflt);
    int          n = 0;
    int          first = 0;
    logic [31:0] first_d = '0;
    logic [31:0] or_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (m_valid[i] && m_key[i] == key) begin
        if (n == 0) begin
          first   = i;
          first_d = m_data[i];
        end
        or_d = or_d | m_data[i];
        n++;
      end
    end
    if (n == 0) return {3'b100, 2'b00, (hasdef ? dflt : 32'h0)};
    return {1'b1, 1'b1, (n > 1), 2'(first), (prio ? first_d : or_d)};
  endfunction

  // Advance one clock: update the model from the inputs present at the edge, then sample.
  task automatic tick();
    bit acc;
    acc = req_valid && (!exp_p[36] || rsp_ready);
    if (reset) begin
      exp_p = '0;
      exp_m = '0;
      for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    end else begin
      if (acc) begin
        exp_p = model_rsp(req_key, 1'b1, 1'b1, default_out);
        exp_m = model_rsp(req_key, 1'b0, 1'b0, default_out);
      end else if (rsp_ready) begin
        exp_p[36] = 1'b0;
        exp_m[36] = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        if (wr_en && int'(wr_idx) == i) begin
          m_key[i]   = wr_key;
          m_data[i]  = wr_data;
          m_valid[i] = wr_valid;
        end else if (clear_all) begin
          m_valid[i] = 1'b0;
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_key = '0; wr_data = '0; wr_valid = 1'b0;
    clear_all = 1'b0; req_valid = 1'b0; req_key = '0; rsp_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    default_out = 32'h0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (got_p !== 37'h0 || got_m !== 37'h0) begin
      failures++;
      $display("FAIL reset_state got=%h/%h exp=0", got_p, got_m);
    end
    checks++;
    if (req_ready_p !== 1'b1 || req_ready_m !== 1'b1) begin
      failures++;
      $display("FAIL reset_req_ready got=%b/%b exp=1", req_ready_p, req_ready_m);
    end
  endtask

  task automatic test_miss_default();
    idle_inputs();
    default_out = 32'hDEAD;
    req_valid = 1'b1; req_key = 8'h05;
    tick();
    checks++;
    if (got_p !== {3'b100, 2'd0, 32'hDEAD} || got_p !== exp_p) begin
      failures++;
      $display("FAIL miss_default got=%h exp=%h", got_p, {3'b100, 2'd0, 32'hDEAD});
    end
    checks++;
    if (got_m !== {3'b100, 2'd0, 32'h0}) begin
      failures++;
      $display("FAIL miss_no_default got=%h exp=%h", got_m, {3'b100, 2'd0, 32'h0});
    end
  endtask

  task automatic test_write_hit();
    idle_inputs();
    wr_en = 1'b1; wr_idx = 2'd2; wr_key = 8'h05; wr_data = 32'h1234; wr_valid = 1'b1;
    tick();
    idle_inputs();
    req_valid = 1'b1; req_key = 8'h05;
    tick();
    checks++;
    if (got_p !== {3'b110, 2'd2, 32'h1234} || got_p !== exp_p) begin
      failures++;
      $display("FAIL write_hit got=%h exp=%h", got_p, {3'b110, 2'd2, 32'h1234});
    end
  endtask

  task automatic test_multi();
    idle_inputs();
    wr_en = 1'b1; wr_idx = 2'd1; wr_key = 8'h07; wr_data = 32'h00F0; wr_valid = 1'b1;
    tick();
    wr_idx = 2'd3; wr_data = 32'h0F00;
    tick();
    idle_inputs();
    req_valid = 1'b1; req_key = 8'h07;
    tick();
    checks++;
    if (got_p !== {3'b111, 2'd1, 32'h00F0} || got_p !== exp_p) begin
      failures++;
      $display("FAIL multi_priority got=%h exp=%h", got_p, {3'b111, 2'd1, 32'h00F0});
    end
    checks++;
    if (got_m !== {3'b111, 2'd1, 32'h0FF0} || got_m !== exp_m) begin
      failures++;
      $display("FAIL multi_merge got=%h exp=%h", got_m, {3'b111, 2'd1, 32'h0FF0});
    end
  endtask

  task automatic test_backpressure();
    logic [36:0] snap_p, snap_m;
    idle_inputs();
    req_valid = 1'b1; req_key = 8'h05;
    tick();
    snap_p = exp_p;
    snap_m = exp_m;
    rsp_ready = 1'b0;
    req_key = 8'h07;
    wr_en = 1'b1; wr_idx = 2'd2; wr_key = 8'h05; wr_data = 32'h5555; wr_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (req_ready_p !== 1'b0 || req_ready_m !== 1'b0) begin
        failures++;
        $display("FAIL hold_req_ready cyc=%0d got=%b/%b exp=0", c, req_ready_p, req_ready_m);
      end
      tick();
      checks++;
      if (got_p !== snap_p || got_m !== snap_m || got_p !== exp_p) begin
        failures++;
        $display("FAIL hold_stable cyc=%0d got=%h/%h exp=%h/%h", c, got_p, got_m, snap_p, snap_m);
      end
    end
    wr_en = 1'b0;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready_p !== 1'b1) begin
      failures++;
      $display("FAIL release_req_ready got=%b exp=1", req_ready_p);
    end
    tick();
    checks++;
    if (got_p !== {3'b111, 2'd1, 32'h00F0} || got_p !== exp_p) begin
      failures++;
      $display("FAIL release_next got=%h exp=%h", got_p, {3'b111, 2'd1, 32'h00F0});
    end
  endtask

  task automatic test_same_cycle_write();
    idle_inputs();
    wr_en = 1'b1; wr_idx = 2'd0; wr_key = 8'h09; wr_data = 32'hAAAA; wr_valid = 1'b1;
    req_valid = 1'b1; req_key = 8'h09;
    default_out = 32'hBEEF;
    tick();
    checks++;
    if (got_p !== {3'b100, 2'd0, 32'hBEEF} || got_p !== exp_p) begin
      failures++;
      $display("FAIL same_cycle_miss got=%h exp=%h", got_p, {3'b100, 2'd0, 32'hBEEF});
    end
    wr_en = 1'b0;
    tick();
    checks++;
    if (got_p !== {3'b110, 2'd0, 32'hAAAA} || got_p !== exp_p) begin
      failures++;
      $display("FAIL next_cycle_hit got=%h exp=%h", got_p, {3'b110, 2'd0, 32'hAAAA});
    end
  endtask

  task automatic test_clear_write();
    idle_inputs();
    clear_all = 1'b1;
    wr_en = 1'b1; wr_idx = 2'd1; wr_key = 8'h07; wr_data = 32'h0001; wr_valid = 1'b1;
    req_valid = 1'b1; req_key = 8'h07;
    tick();
    checks++;
    if (got_p !== {3'b111, 2'd1, 32'h00F0} || got_p !== exp_p) begin
      failures++;
      $display("FAIL clear_sees_old got=%h exp=%h", got_p, {3'b111, 2'd1, 32'h00F0});
    end
    clear_all = 1'b0; wr_en = 1'b0;
    tick();
    checks++;
    if (got_p !== {3'b110, 2'd1, 32'h0001} || got_m !== exp_m) begin
      failures++;
      $display("FAIL clear_then_write got=%h exp=%h", got_p, {3'b110, 2'd1, 32'h0001});
    end
    req_key = 8'h09;
    tick();
    checks++;
    if (got_p[35] !== 1'b0 || got_p !== exp_p) begin
      failures++;
      $display("FAIL cleared_entry0 got=%h exp=%h", got_p, exp_p);
    end
  endtask

  task automatic test_reset_inflight();
    idle_inputs();
    req_valid = 1'b1; req_key = 8'h07; rsp_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (got_p !== 37'h0 || got_m !== 37'h0) begin
      failures++;
      $display("FAIL reset_inflight got=%h/%h exp=0", got_p, got_m);
    end
    reset = 1'b0; rsp_ready = 1'b1; default_out = 32'h0;
    for (int k = 0; k < 4; k++) begin
      req_key = (k == 3) ? 8'h00 : 8'h05 + 8'(2 * k);
      tick();
      checks++;
      if (got_p !== {3'b100, 2'd0, 32'h0} || got_m !== {3'b100, 2'd0, 32'h0}) begin
        failures++;
        $display("FAIL post_reset_miss key=%h got=%h/%h exp=%h", req_key, got_p, got_m,
                 {3'b100, 2'd0, 32'h0});
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset       = ($urandom_range(63) == 0);
      wr_en       = ($urandom_range(2) == 0);
      wr_idx      = 2'($urandom_range(3));
      wr_key      = 8'($urandom_range(7));
      wr_data     = $urandom;
      wr_valid    = ($urandom_range(3) != 0);
      clear_all   = ($urandom_range(31) == 0);
      default_out = $urandom;
      req_valid   = ($urandom_range(3) != 0);
      req_key     = 8'($urandom_range(7));
      rsp_ready   = ($urandom_range(2) != 0);
      #1;
      checks++;
      if (req_ready_p !== (!exp_p[36] || rsp_ready) || req_ready_m !== req_ready_p) begin
        failures++;
        $display("FAIL rand_req_ready cyc=%0d got=%b/%b exp=%b", c, req_ready_p, req_ready_m,
                 (!exp_p[36] || rsp_ready));
      end
      tick();
      checks++;
      if ((exp_p[36] ? got_p : {got_p[36], 36'h0}) !== (exp_p[36] ? exp_p : {exp_p[36], 36'h0}) ||
          (exp_m[36] ? got_m : {got_m[36], 36'h0}) !== (exp_m[36] ? exp_m : {exp_m[36], 36'h0})) begin
        failures++;
        $display("FAIL rand_rsp cyc=%0d got=%h/%h exp=%h/%h", c, got_p, got_m, exp_p, exp_m);
      end
    end
  endtask

  initial begin
    exp_p = '0;
    exp_m = '0;
    for (int i = 0; i < 4; i++) begin
      m_key[i]   = '0;
      m_data[i]  = '0;
      m_valid[i] = 1'b0;
    end
    test_reset();
    test_miss_default();
    test_write_hit();
    test_multi();
    test_backpressure();
    test_same_cycle_write();
    test_clear_write();
    test_reset_inflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
